// File: rtl/router_pkg.sv
// Shared types and defaults for the router control FSM and its wait timer.
package router_pkg;

  localparam int unsigned DefaultNumPorts  = 3;
  localparam int unsigned DefaultWaitLimit = 30;

  typedef enum logic [3:0] {
    StDecode        = 4'd0,
    StWaitEmpty     = 4'd1,
    StLoadFirst     = 4'd2,
    StLoadData      = 4'd3,
    StLoadParity    = 4'd4,
    StFifoFull      = 4'd5,
    StLoadAfterFull = 4'd6,
    StCheckParity   = 4'd7,
    StDrop          = 4'd8
  } router_state_e;

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Status/handshake bundle between the router datapath (master) and the control FSM (slave).
interface router_ctrl_fsm_if import router_pkg::*; #(
  parameter int unsigned NUM_PORTS = DefaultNumPorts,
  parameter int unsigned ADDR_W    = $clog2(NUM_PORTS)
);

  logic                 packet_valid;
  logic [ADDR_W-1:0]    addr_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_packet_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 write_enb_reg;
  logic                 rst_int_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    port_sel;
  logic                 drop_pkt;

  modport master (
    output packet_valid, addr_in, fifo_full, fifo_empty, soft_reset, parity_done,
           low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, port_sel, drop_pkt
  );

  modport slave (
    input  packet_valid, addr_in, fifo_full, fifo_empty, soft_reset, parity_done,
           low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
           rst_int_reg, busy, port_sel, drop_pkt
  );

endinterface

// File: rtl/router_wait_timer.sv
// Counts consecutive WAIT_EMPTY cycles; expired once WAIT_LIMIT cycles have been spent there.
module router_wait_timer import router_pkg::*; #(
  parameter int unsigned WAIT_LIMIT = DefaultWaitLimit
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(WAIT_LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q counts cycles already spent waiting, so the last permitted cycle sees LIMIT-1
  assign expired = (cnt_q == CntW'(WAIT_LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (start && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router packet-flow control FSM with Moore state decodes.
// Define ROUTER_WAIT_TIMEOUT_EN to drop packets that wait too long for an empty FIFO.
module router_ctrl_fsm import router_pkg::*; #(
  parameter int unsigned NUM_PORTS  = DefaultNumPorts,
  parameter int unsigned ADDR_W     = $clog2(NUM_PORTS),
  parameter int unsigned WAIT_LIMIT = DefaultWaitLimit
) (
  input logic              clk,
  input logic              resetn,
  router_ctrl_fsm_if.slave bus
);

  localparam int unsigned PadW = 1 << ADDR_W;

  router_state_e     state_q, state_d;
  logic [ADDR_W-1:0] port_sel_q, port_sel_d;
  logic [PadW-1:0]   empty_pad, srst_pad;
  logic              addr_ok;
  logic              timer_expired;

  // Pad per-port vectors to the full address space so out-of-range addresses read as 0
  assign empty_pad = PadW'(bus.fifo_empty);
  assign srst_pad  = PadW'(bus.soft_reset);
  assign addr_ok   = (32'(bus.addr_in) < NUM_PORTS);

`ifdef ROUTER_WAIT_TIMEOUT_EN
  router_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .start  (state_q == StWaitEmpty),
    .clear  (state_d != StWaitEmpty),
    .expired(timer_expired)
  );
`else
  logic unused_wait_limit;
  assign unused_wait_limit = ^WAIT_LIMIT;
  assign timer_expired     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    port_sel_d = port_sel_q;
    case (state_q)
      StDecode: begin
        if (bus.packet_valid) begin
          port_sel_d = bus.addr_in;
          if (!addr_ok)                       state_d = StDrop;
          else if (empty_pad[bus.addr_in])    state_d = StLoadFirst;
          else                                state_d = StWaitEmpty;
        end
      end
      StWaitEmpty: begin
        if (empty_pad[port_sel_q])            state_d = StLoadFirst;
        else if (timer_expired)               state_d = StDrop;
      end
      StLoadFirst:                            state_d = StLoadData;
      StLoadData: begin
        if (bus.fifo_full)                    state_d = StFifoFull;
        else if (!bus.packet_valid)           state_d = StLoadParity;
      end
      StFifoFull: begin
        if (!bus.fifo_full)                   state_d = StLoadAfterFull;
      end
      StLoadAfterFull: begin
        if (bus.parity_done)                  state_d = StDecode;
        else if (bus.low_packet_valid)        state_d = StLoadParity;
        else                                  state_d = StLoadData;
      end
      StLoadParity:                           state_d = StCheckParity;
      StCheckParity: begin
        state_d = bus.fifo_full ? StFifoFull : StDecode;
      end
      StDrop: begin
        if (!bus.packet_valid)                state_d = StDecode;
      end
      default:                                state_d = StDecode;
    endcase
    // Only the soft reset of the latched destination aborts the packet
    if (state_q != StDecode && srst_pad[port_sel_q]) begin
      state_d = StDecode;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StDecode;
      port_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      port_sel_q <= port_sel_d;
    end
  end

  assign bus.detect_add    = (state_q == StDecode);
  assign bus.lfd_state     = (state_q == StLoadFirst);
  assign bus.ld_state      = (state_q == StLoadData);
  assign bus.laf_state     = (state_q == StLoadAfterFull);
  assign bus.full_state    = (state_q == StFifoFull);
  assign bus.rst_int_reg   = (state_q == StCheckParity);
  assign bus.write_enb_reg = (state_q == StLoadData) || (state_q == StLoadAfterFull) ||
                             (state_q == StLoadParity);
  assign bus.busy          = (state_q != StDecode) && (state_q != StLoadData);
  assign bus.drop_pkt      = (state_q == StDrop);
  assign bus.port_sel      = port_sel_q;

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Vector-table bench for router_ctrl_fsm with a queue of expected output snapshots.
module tb_router_ctrl_fsm;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 2;
  localparam int unsigned WL = 4;
`ifdef ROUTER_WAIT_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;

  router_ctrl_fsm_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

  router_ctrl_fsm #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .WAIT_LIMIT(WL)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef enum int {SD, SW, SLF, SLD, SLP, SFF, SLAF, SCP, SDR} st_t;

  typedef struct {
    logic       rn;
    logic       pv;
    logic [1:0] addr;
    logic       full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       pdone;
    logic       lpv;
    st_t        exp;
    logic [1:0] exp_ps;
  } vec_t;

  vec_t        vecs[$];
  logic [10:0] sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy, drop}
  function automatic logic [8:0] decode(st_t s);
    case (s)
      SD:      return 9'b100000000;
      SW:      return 9'b000000010;
      SLF:     return 9'b010000010;
      SLD:     return 9'b001001000;
      SLP:     return 9'b000001010;
      SFF:     return 9'b000010010;
      SLAF:    return 9'b000101010;
      SCP:     return 9'b000000110;
      default: return 9'b000000011;
    endcase
  endfunction

  function automatic vec_t mk(logic rn, logic pv, logic [1:0] a, logic f, logic [2:0] e,
                              logic [2:0] s, logic pd, logic lp, st_t x, logic [1:0] ps);
    vec_t v;
    v.rn = rn; v.pv = pv; v.addr = a; v.full = f; v.empty = e; v.srst = s;
    v.pdone = pd; v.lpv = lp; v.exp = x; v.exp_ps = ps;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [10:0] exp_v, act_v;
    resetn               = v.rn;
    bus.packet_valid     = v.pv;
    bus.addr_in          = v.addr;
    bus.fifo_full        = v.full;
    bus.fifo_empty       = v.empty;
    bus.soft_reset       = v.srst;
    bus.parity_done      = v.pdone;
    bus.low_packet_valid = v.lpv;
    sb_q.push_back({decode(v.exp), v.exp_ps});
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    act_v = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
             bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_pkt, bus.port_sel};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: outputs+port_sel got %b expected %b", name, act_v, exp_v);
    end
  endtask

  initial begin
    // reset
    vecs.push_back(mk(0, 0, 0, 0, 3'b111, 0, 0, 0, SD,  0));
    // normal packet to port 2
    vecs.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, SLF, 2));
    repeat (4) vecs.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, SLD, 2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SLP, 2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SCP, 2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SD,  2));
    // out-of-range address dropped
    vecs.push_back(mk(1, 1, 3, 0, 3'b111, 0, 0, 0, SDR, 3));
    vecs.push_back(mk(1, 1, 3, 0, 3'b111, 0, 0, 0, SDR, 3));
    vecs.push_back(mk(1, 0, 3, 0, 3'b111, 0, 0, 0, SD,  3));
    // fifo_full for 3 cycles, then low_packet_valid
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0, 0, 0, SLF, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0, 0, 0, SLD, 1));
    repeat (3) vecs.push_back(mk(1, 1, 1, 1, 3'b111, 0, 0, 0, SFF, 1));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0, 0, 1, SLAF, 1));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0, 0, 1, SLP, 1));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0, 0, 0, SCP, 1));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0, 0, 0, SD,  1));
    // soft reset: other port ignored, own port aborts
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0,      0, 0, SLF, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0,      0, 0, SLD, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 3'b100, 0, 0, SLD, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 3'b010, 0, 0, SD,  1));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0,      0, 0, SD,  1));
    // LOAD_AFTER_FULL back to LOAD_DATA, then out via parity_done
    vecs.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, SLF,  0));
    vecs.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, SLD,  0));
    vecs.push_back(mk(1, 1, 0, 1, 3'b111, 0, 0, 0, SFF,  0));
    vecs.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, SLAF, 0));
    vecs.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, SLD,  0));
    vecs.push_back(mk(1, 1, 0, 1, 3'b111, 0, 0, 0, SFF,  0));
    vecs.push_back(mk(1, 1, 0, 0, 3'b111, 0, 0, 0, SLAF, 0));
    vecs.push_back(mk(1, 0, 0, 0, 3'b111, 0, 1, 0, SD,   0));
    // short WAIT_EMPTY, then CHECK_PARITY into FIFO_FULL
    vecs.push_back(mk(1, 1, 2, 0, 3'b011, 0, 0, 0, SW,   2));
    vecs.push_back(mk(1, 1, 2, 0, 3'b011, 0, 0, 0, SW,   2));
    vecs.push_back(mk(1, 1, 2, 0, 3'b111, 0, 0, 0, SLF,  2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SLD,  2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SLP,  2));
    vecs.push_back(mk(1, 0, 2, 1, 3'b111, 0, 0, 0, SCP,  2));
    vecs.push_back(mk(1, 0, 2, 1, 3'b111, 0, 0, 0, SFF,  2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 0, 0, SLAF, 2));
    vecs.push_back(mk(1, 0, 2, 0, 3'b111, 0, 1, 0, SD,   2));
    // reset beats soft reset in FIFO_FULL
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0,      0, 0, SLF, 1));
    vecs.push_back(mk(1, 1, 1, 0, 3'b111, 0,      0, 0, SLD, 1));
    vecs.push_back(mk(1, 1, 1, 1, 3'b111, 0,      0, 0, SFF, 1));
    vecs.push_back(mk(0, 1, 1, 1, 3'b111, 3'b010, 0, 0, SD,  0));
    vecs.push_back(mk(1, 0, 1, 0, 3'b111, 0,      0, 0, SD,  0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Long wait on a never-empty FIFO, twice so a stale count would shorten the second run
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) begin
        apply(mk(1, 1, 1, 0, 3'b101, 0, 0, 0, (TimeoutEn && i >= int'(WL)) ? SDR : SW, 1),
              $sformatf("wait%0d_%0d", r, i));
      end
      apply(mk(1, 0, 1, 0, 3'b101, 3'b010, 0, 0, SD, 1), $sformatf("wait%0d_exit", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
